wrap_event_fifo: RTL and testbench

WRAP_EVENT_FIFO -- requirements
Module: wrap_event_fifo

---
 rtl/wrap_event_fifo.sv | 107 ++++++++++
 tb/tb_wrap_event_fifo.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/wrap_event_fifo.sv
// Detects wraps of an upstream mod-N counter and queues the running wrap epoch in a small FIFO.
// Optional drop counter output enabled by defining WRAP_FIFO_DROP_CNT_EN.
module wrap_event_fifo #(
  parameter int N       = 15,
  parameter int WIDTH   = 4,
  parameter int EPOCH_W = 8,
  parameter int DEPTH   = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   cnt_in,
  input  logic               cnt_adv,
  output logic [EPOCH_W-1:0] ev_data,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [AW:0]        fifo_level,
`ifdef WRAP_FIFO_DROP_CNT_EN
  output logic [7:0]         drop_cnt,
`endif
  output logic               ovf,
  input  logic               clr_ovf
);

  logic [EPOCH_W-1:0] mem_reg [DEPTH];
  logic [EPOCH_W-1:0] epoch_reg, epoch_next;
  logic [EPOCH_W-1:0] ev_data_reg, ev_data_next;
  logic [AW-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [AW:0]        level_reg, level_next, remain;
  logic               ev_valid_reg;
  logic               ovf_reg, ovf_next;
  logic               wrap, pop, push, drop, full;

  always_comb begin
    wrap        = cnt_adv && (cnt_in == WIDTH'(N - 1));
    full        = (level_reg == (AW+1)'(DEPTH));
    pop         = ev_valid_reg && ev_ready;
    push        = wrap && (!full || pop);
    drop        = wrap && !push;
    epoch_next  = wrap ? epoch_reg + EPOCH_W'(1) : epoch_reg;
    wr_ptr_next = push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
    rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    remain      = level_reg - (AW+1)'(pop);
    level_next  = remain + (AW+1)'(push);
    ovf_next    = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_reg);
    // Head after this edge: empty -> 0; only the new entry -> bypass the write; else stored entry
    ev_data_next = '0;
    if (level_next != '0) begin
      if (remain == '0) ev_data_next = epoch_next;
      else              ev_data_next = mem_reg[rd_ptr_next];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (!rst && push && (wr_ptr_reg == AW'(gi))) mem_reg[gi] <= epoch_next;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      ev_valid_reg <= 1'b0;
      ev_data_reg  <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      epoch_reg    <= epoch_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      ev_valid_reg <= (level_next != '0);
      ev_data_reg  <= ev_data_next;
      ovf_reg      <= ovf_next;
    end
  end

`ifdef WRAP_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_reg, drop_cnt_next;

  // A clear coinciding with a drop restarts the count at one
  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (clr_ovf)                            drop_cnt_next = drop ? 8'd1 : 8'd0;
    else if (drop && drop_cnt_reg != 8'hFF) drop_cnt_next = drop_cnt_reg + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_reg <= '0;
    else     drop_cnt_reg <= drop_cnt_next;
  end

  assign drop_cnt = drop_cnt_reg;
`endif

  assign ev_data    = ev_data_reg;
  assign ev_valid   = ev_valid_reg;
  assign fifo_level = level_reg;
  assign ovf        = ovf_reg;

endmodule

// File: tb/tb_wrap_event_fifo.sv
// Directed bench for wrap_event_fifo: a reference queue holds expected epochs, compared on every pop and cycle.
module tb_wrap_event_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cnt_in;
  logic       cnt_adv;
  logic [7:0] ev_data;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] fifo_level;
  logic       ovf;
  logic       clr_ovf;
`ifdef WRAP_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0] sb_q[$];
  logic [7:0] m_epoch;
  logic       m_ovf;
  logic [7:0] m_drop;

  always #5 clk = ~clk;

  wrap_event_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .cnt_adv    (cnt_adv),
    .ev_data    (ev_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .fifo_level (fifo_level),
`ifdef WRAP_FIFO_DROP_CNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .ovf        (ovf),
    .clr_ovf    (clr_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":level"}, 32'(fifo_level), 32'(sb_q.size()));
    chk({tag, ":valid"}, 32'(ev_valid), 32'(sb_q.size() != 0));
    chk({tag, ":data"}, 32'(ev_data), (sb_q.size() != 0) ? 32'(sb_q[0]) : 32'd0);
    chk({tag, ":ovf"}, 32'(ovf), 32'(m_ovf));
`ifdef WRAP_FIFO_DROP_CNT_EN
    chk({tag, ":drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  // One clock edge: drive inputs, update reference model, compare after the edge
  task automatic step(input string tag, input logic adv, input logic [3:0] c,
                      input logic rdy, input logic clr, input logic rs);
    logic wrap, pop, push, drop;
    logic [7:0] head;
    cnt_adv = adv; cnt_in = c; ev_ready = rdy; clr_ovf = clr; rst = rs;
    if (rs) begin
      sb_q.delete(); m_epoch = 0; m_ovf = 0; m_drop = 0;
    end else begin
      wrap = adv && (c == 4'd14);
      pop  = (sb_q.size() != 0) && rdy;
      push = wrap && (sb_q.size() < 4 || pop);
      drop = wrap && !push;
      if (wrap) m_epoch = m_epoch + 8'd1;
      if (pop) begin
        head = sb_q.pop_front();
        chk({tag, ":pop"}, 32'(ev_data), 32'(head));
        $display("[TB] %s pop data=%0d expected=%0d", tag, ev_data, head);
      end
      if (push) sb_q.push_back(m_epoch);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (clr) m_drop = drop ? 8'd1 : 8'd0;
      else if (drop && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    rst = 1'b1; cnt_in = 0; cnt_adv = 0; ev_ready = 0; clr_ovf = 0;
    sb_q.delete(); m_epoch = 0; m_ovf = 0; m_drop = 0;
    step("reset", 1'b1, 4'd14, 1'b1, 1'b0, 1'b1);
    step("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Two full count sequences with no consumer: entries 1 and 2
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 15; i++) step("count", 1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
    chk("two_wraps_level", 32'(fifo_level), 32'd2);
    chk("two_wraps_head", 32'(ev_data), 32'd1);

    // Four more wraps: 3,4 stored, 5,6 dropped
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_ovf", 32'(ovf), 32'd1);

    // Clear coinciding with a drop, then a clear alone
    step("clr_drop", 1'b1, 4'd14, 1'b0, 1'b1, 1'b0);
    chk("clr_drop_ovf", 32'(ovf), 32'd1);
    step("clr_only", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("clr_only_ovf", 32'(ovf), 32'd0);

    // Full with a pop on the wrap edge: push accepted, level held
    step("full_pp", 1'b1, 4'd14, 1'b1, 1'b0, 1'b0);
    chk("full_pp_level", 32'(fifo_level), 32'd4);
    chk("full_pp_ovf", 32'(ovf), 32'd0);

    // Non-events
    step("no_adv", 1'b0, 4'd14, 1'b0, 1'b0, 1'b0);
    step("out_rng", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);

    // Drain past empty
    for (int i = 0; i < 6; i++) step("drain", 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    chk("drained_level", 32'(fifo_level), 32'd0);

    // Push into empty: valid appears the following cycle only
    step("empty_push", 1'b1, 4'd14, 1'b1, 1'b0, 1'b0);
    step("empty_push2", 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
    step("empty_push3", 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);

    // Reset with a wrap on the same edge, then first wrap pushes 1
    step("mid_rst", 1'b1, 4'd14, 1'b1, 1'b1, 1'b1);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    step("post_rst", 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
    step("post_rst2", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_head", 32'(ev_data), 32'd1);

    // Random mix
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(12, 15)),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
